// File: rtl/spike_cnt_gen_pkg.sv
// Shared float32 field constants and FSM encoding for the spike count generator.
package spike_cnt_gen_pkg;

    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_ACCUM = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/spike_cnt_gen_float_to_fix.sv
// Combinational float32 -> unsigned Q(CNT_W).(FRAC_W) conversion, truncating toward zero.
module float_to_fix
    import spike_cnt_gen_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic [FP_W-1:0]          i_f,
    output logic [CNT_W+FRAC_W-1:0]  o_fix,
    output logic                     o_sat
);

    localparam int TOT_W = CNT_W + FRAC_W;
    localparam int SH_W  = $clog2(TOT_W);

    logic                  w_sign;
    logic [FP_EXP_W-1:0]   w_exp;
    logic [FP_MAN_W-1:0]   w_man;
    logic [TOT_W+23:0]     w_wide;
    int                    w_sh;

    assign w_sign = i_f[FP_W-1];
    assign w_exp  = i_f[FP_W-2:FP_MAN_W];
    assign w_man  = i_f[FP_MAN_W-1:0];

    // w_sh is the left shift of {1,mant} before dropping the 23 mantissa fraction bits.
    always_comb begin
        o_fix  = '0;
        o_sat  = 1'b0;
        w_wide = '0;
        w_sh   = int'(w_exp) - FP_BIAS + FRAC_W;
        if (w_sign || (w_exp == '0)) begin
            o_fix = '0;
        end else if (w_exp == '1) begin
            if (w_man == '0) begin
                o_fix = '1;
                o_sat = 1'b1;
            end
        end else if (w_sh < 0) begin
            o_fix = '0;
        end else if (w_sh >= TOT_W) begin
            o_fix = '1;
            o_sat = 1'b1;
        end else begin
            w_wide = {{TOT_W{1'b0}}, 1'b1, w_man} << w_sh[SH_W-1:0];
            o_fix  = w_wide[TOT_W+22:23];
        end
    end

endmodule

// File: rtl/spike_cnt_gen.sv
// Turns a float32 firing rate into a per-step integer spike count via a phase
// accumulator, and replays each count as a serialized pulse train.
module spike_cnt_gen
    import spike_cnt_gen_pkg::*;
#(
    parameter int FRAC_W    = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_CNT   = 255,
    parameter int PULSE_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [FP_W-1:0]  rate_f,
    output logic [31:0]      spike_cnt,
    output logic             cnt_valid,
    output logic             spike_pulse,
    output logic             busy,
    output logic             sat,
    output logic             missed_step,
    output state_t           dbg_state
);

    localparam int TOT_W = CNT_W + FRAC_W;
    localparam int GAP_W = $clog2(PULSE_GAP + 1);

    state_t                r_state;
    state_t                w_state_n;
    logic [TOT_W-1:0]      r_fix;
    logic                  r_conv_sat;
    logic [FRAC_W-1:0]     r_frac;
    logic [CNT_W:0]        r_pcnt;
    logic [GAP_W-1:0]      r_gap;

    logic [TOT_W-1:0]      w_fix;
    logic                  w_fix_sat;
    logic [TOT_W:0]        w_sum;
    logic [CNT_W:0]        w_int;
    logic                  w_clip_sat;
    logic [CNT_W:0]        w_clip;
    logic                  w_accept;
    logic                  w_fire;

    float_to_fix #(
        .FRAC_W (FRAC_W),
        .CNT_W  (CNT_W)
    ) u_f2x (
        .i_f    (rate_f),
        .o_fix  (w_fix),
        .o_sat  (w_fix_sat)
    );

    // The carry out of the fraction lands in the integer field before clipping.
    assign w_sum      = {1'b0, {CNT_W{1'b0}}, r_frac} + {1'b0, r_fix};
    assign w_int      = w_sum[TOT_W:FRAC_W];
    assign w_clip_sat = (w_int > (CNT_W+1)'(MAX_CNT));
    assign w_clip     = w_clip_sat ? (CNT_W+1)'(MAX_CNT) : w_int;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step) begin
                    w_state_n = S_CONV;
                    w_accept  = 1'b1;
                end
            end
            S_CONV: w_state_n = S_ACCUM;
            S_ACCUM: begin
                if (r_pcnt == '0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_EMIT;
                    w_fire    = 1'b1;
                end
            end
            S_EMIT: begin
                if (r_gap == '0) begin
                    if (r_pcnt == '0) w_state_n = S_IDLE;
                    else              w_fire    = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs are registered one state early so the count is visible during ACCUM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fix       <= '0;
            r_conv_sat  <= 1'b0;
            r_frac      <= '0;
            r_pcnt      <= '0;
            r_gap       <= '0;
            spike_cnt   <= '0;
            cnt_valid   <= 1'b0;
            spike_pulse <= 1'b0;
            busy        <= 1'b0;
            sat         <= 1'b0;
            missed_step <= 1'b0;
        end else begin
            cnt_valid   <= 1'b0;
            spike_pulse <= 1'b0;
            busy        <= (w_state_n != S_IDLE);
            if (step && (r_state != S_IDLE)) begin
                missed_step <= 1'b1;
            end
            if (w_accept) begin
                r_fix      <= w_fix;
                r_conv_sat <= w_fix_sat;
            end
            if (r_state == S_CONV) begin
                spike_cnt <= 32'(w_clip);
                cnt_valid <= 1'b1;
                sat       <= w_clip_sat | r_conv_sat;
                r_frac    <= w_sum[FRAC_W-1:0];
                r_pcnt    <= w_clip;
            end
            if (w_fire) begin
                spike_pulse <= 1'b1;
                r_pcnt      <= r_pcnt - 1'b1;
                r_gap       <= GAP_W'(PULSE_GAP - 1);
            end else if ((r_state == S_EMIT) && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_cnt_gen.sv
// Directed bench for spike_cnt_gen: counts, carry-over, pulse spacing, saturation,
// missed steps and asynchronous reset in the middle of a pulse train.
module tb_spike_cnt_gen;

    localparam int G = 2;

    logic        clk;
    logic        reset;
    logic        step;
    logic [31:0] rate_f;
    logic [31:0] spike_cnt;
    logic        cnt_valid;
    logic        spike_pulse;
    logic        busy;
    logic        sat;
    logic        missed_step;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;

    spike_cnt_gen #(
        .FRAC_W    (16),
        .CNT_W     (16),
        .MAX_CNT   (255),
        .PULSE_GAP (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .rate_f      (rate_f),
        .spike_cnt   (spike_cnt),
        .cnt_valid   (cnt_valid),
        .spike_pulse (spike_pulse),
        .busy        (busy),
        .sat         (sat),
        .missed_step (missed_step),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one step in the current cycle (t) and follows it until busy drops.
    // inj > 0 raises step again during cycle t+inj.
    task automatic do_step(input logic [31:0] rate, input int exp_cnt,
                           input logic exp_sat, input int inj);
        int  k;
        int  npulse;
        int  nbad;
        bit  done;
        bit  exp_p;
        step   = 1'b1;
        rate_f = rate;
        tick();
        step   = 1'b0;
        rate_f = $urandom();
        chk("busy_t1", 32'(busy), 32'd1);
        chk("cv_t1", 32'(cnt_valid), 32'd0);
        tick();
        chk("cv_t2", 32'(cnt_valid), 32'd1);
        chk("cnt_t2", spike_cnt, 32'(exp_cnt));
        chk("sat_t2", 32'(sat), 32'(exp_sat));
        k = 2; npulse = 0; nbad = 0; done = 1'b0;
        while (!done && (k < 700)) begin
            step = (k == inj);
            tick();
            k++;
            exp_p = (k >= 3) && (((k - 3) % G) == 0) && (((k - 3) / G) < exp_cnt);
            if (spike_pulse) npulse++;
            if (spike_pulse !== exp_p) nbad++;
            if (!busy) done = 1'b1;
        end
        step = 1'b0;
        chk("pulse_total", 32'(npulse), 32'(exp_cnt));
        chk("pulse_pos", 32'(nbad), 32'd0);
        chk("busy_end", 32'(k), 32'(3 + exp_cnt * G));
        chk("cnt_hold", spike_cnt, 32'(exp_cnt));
        chk("sat_hold", 32'(sat), 32'(exp_sat));
    endtask

    initial begin
        int nbad;
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        step   = 1'b0;
        rate_f = 32'h0;

        #12;
        chk("rst_cnt", spike_cnt, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(spike_pulse), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_cv", 32'(cnt_valid), 32'd0);
        chk("rel_sat", 32'(sat), 32'd0);
        chk("rel_missed", 32'(missed_step), 32'd0);

        // 0.5 spikes/step alternates 0,1
        for (int i = 0; i < 8; i++) do_step(32'h3F00_0000, i % 2, 1'b0, 0);

        // 2.25: fraction builds to a carry on the fourth step
        do_step(32'h4010_0000, 2, 1'b0, 0);
        do_step(32'h4010_0000, 2, 1'b0, 0);
        do_step(32'h4010_0000, 2, 1'b0, 0);
        do_step(32'h4010_0000, 3, 1'b0, 0);

        // Zero-valued encodings must leave the half-spike fraction in place
        do_step(32'h3F00_0000, 0, 1'b0, 0);
        do_step(32'hBF80_0000, 0, 1'b0, 0);
        do_step(32'h7FC0_0000, 0, 1'b0, 0);
        do_step(32'h8000_0000, 0, 1'b0, 0);
        do_step(32'h0000_0001, 0, 1'b0, 0);
        do_step(32'h3F00_0000, 1, 1'b0, 0);
        chk("missed_pre", 32'(missed_step), 32'd0);

        // 1000.0 clips to 255; step during EMIT is dropped
        do_step(32'h447A_0000, 255, 1'b1, 10);
        chk("missed_emit", 32'(missed_step), 32'd1);

        // +Inf saturates conversion: count 255, fraction becomes 0xFFFF
        do_step(32'h7F80_0000, 255, 1'b1, 0);
        do_step(32'h3F00_0000, 1, 1'b0, 0);

        // 3.0 with reset after the second pulse
        step   = 1'b1;
        rate_f = 32'h4040_0000;
        tick();
        step = 1'b0;
        tick();
        chk("rs_cnt", spike_cnt, 32'd3);
        tick();
        chk("rs_p1", 32'(spike_pulse), 32'd1);
        tick();
        tick();
        chk("rs_p2", 32'(spike_pulse), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_async_cnt", spike_cnt, 32'd0);
        chk("rs_async_pulse", 32'(spike_pulse), 32'd0);
        chk("rs_async_busy", 32'(busy), 32'd0);
        chk("rs_async_missed", 32'(missed_step), 32'd0);
        tick();
        tick();
        #3;
        reset = 1'b1;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (spike_pulse || busy || cnt_valid) nbad++;
        end
        chk("rs_quiet", 32'(nbad), 32'd0);

        // Fraction restarts from zero after reset
        do_step(32'h4040_0000, 3, 1'b0, 0);
        do_step(32'h3F40_0000, 0, 1'b0, 0);

        // Step in the last busy cycle is missed; the following cycle is accepted
        chk("missed_pre2", 32'(missed_step), 32'd0);
        do_step(32'h3F80_0000, 1, 1'b0, 2 + G);
        chk("missed_edge", 32'(missed_step), 32'd1);
        do_step(32'h3F80_0000, 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
